// File: rtl/id_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
// Shared decode constants for the ID stage:
//   - MIPS32 opcode / funct encodings of the logic-class subset
//   - ALU operation and result-select codes
//   - NOP register address (register $zero)
//   - id_ex_ctl_t: width-independent control portion of the ID/EX record.
//     Operand, destination and pc widths depend on the stage parameters, so
//     the full id_ex_t record is built in id_fwd_stage around this type.
// ----------------------------------------------------------------------------
package id_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;

  localparam int unsigned NOP_REG_ADDR = 0;

  typedef enum logic [7:0] {
    ALUOP_NOP = 8'h00,
    ALUOP_AND = 8'h24,
    ALUOP_OR  = 8'h25,
    ALUOP_XOR = 8'h26,
    ALUOP_NOR = 8'h27
  } aluop_e;

  typedef enum logic [2:0] {
    ALUSEL_NOP   = 3'b000,
    ALUSEL_LOGIC = 3'b001
  } alusel_e;

  typedef struct packed {
    aluop_e  aluop;
    alusel_e alusel;
    logic    wreg;
    logic    invalid;
  } id_ex_ctl_t;

endpackage

// File: rtl/id_fwd_mux.sv
// ----------------------------------------------------------------------------
// id_fwd_mux
// Priority operand selector for one source operand.
//   read_i       operand is read from the register file (else imm_i is used)
//   addr_i       register address of the operand
//   imm_i        immediate value used when the operand is not read
//   rf_data_i    register file read data
//   fwd_wreg_i   per-source write enable, source 0 = youngest
//   fwd_wd_i     per-source destination, source k at slice k
//   fwd_wdata_i  per-source result, source k at slice k
//   data_o       resolved operand
// Register 0 always reads as zero and is never forwarded.
// ----------------------------------------------------------------------------
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      read_i,
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [DATA_W-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]         data_o
);

  always_comb begin
    data_o = rf_data_i;
    // Walk from oldest to youngest so the youngest matching source wins.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == addr_i)) begin
        data_o = fwd_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    if (addr_i == '0) begin
      data_o = '0;
    end
    if (!read_i) begin
      data_o = imm_i;
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// ----------------------------------------------------------------------------
// id_fwd_stage
// Decode stage for the MIPS32 logic-class subset with operand forwarding,
// load-use hazard detection and a registered ID/EX output slot using a
// valid/ready handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o  IF/ID side handshake
//   pc_i, inst_i             instruction address and word
//   flush_i                  drop the input and empty the output slot
//   reg1/2_read_o, _addr_o   register file read port control (combinational)
//   reg1/2_data_i            register file read data
//   fwd_wreg_i, fwd_wd_i,
//   fwd_wdata_i              NUM_FWD forwarding sources, index 0 = youngest
//   ex_is_load_i             source 0 is a load whose data is not ready
//   stall_req_o              load-use hazard on a valid, unflushed input
//   out_valid_o/out_ready_i  ID/EX side handshake
//   aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o
//                            registered ID/EX slot contents
//   stall_cnt_o              stall cycle counter (only with ID_PERF_CNT_EN)
//
// Build option: define ID_PERF_CNT_EN to add the 32-bit stall counter.
// ----------------------------------------------------------------------------
module id_fwd_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      flush_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      ex_is_load_i,
  output logic                      stall_req_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [REG_AW-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [DATA_W-1:0]         pc_o,
  output logic                      inst_invalid_o
`ifdef ID_PERF_CNT_EN
 ,output logic [31:0]               stall_cnt_o
`endif
);

  typedef struct packed {
    id_ex_ctl_t          ctl;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [REG_AW-1:0]   wd;
    logic [DATA_W-1:0]   pc;
  } id_ex_t;

  localparam logic [REG_AW-1:0] NOP_ADDR = REG_AW'(NOP_REG_ADDR);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign shamt = inst_i[10:6];
  assign rs    = REG_AW'(inst_i[25:21]);
  assign rt    = REG_AW'(inst_i[20:16]);
  assign rd    = REG_AW'(inst_i[15:11]);

  id_ex_ctl_t        ctl_dec;
  logic [REG_AW-1:0] wd_dec;
  logic [DATA_W-1:0] imm_dec;

  always_comb begin
    ctl_dec.aluop   = ALUOP_NOP;
    ctl_dec.alusel  = ALUSEL_NOP;
    ctl_dec.wreg    = 1'b0;
    ctl_dec.invalid = 1'b1;
    wd_dec          = NOP_ADDR;
    imm_dec         = '0;
    reg1_read_o     = 1'b0;
    reg2_read_o     = 1'b0;
    reg1_addr_o     = rs;
    reg2_addr_o     = rt;

    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        reg1_read_o     = 1'b1;
        imm_dec         = DATA_W'(inst_i[15:0]);
        wd_dec          = rt;
        ctl_dec.wreg    = 1'b1;
        ctl_dec.invalid = 1'b0;
        ctl_dec.alusel  = ALUSEL_LOGIC;
        ctl_dec.aluop   = (op == OP_ORI)  ? ALUOP_OR  :
                          (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
      end
      OP_LUI: begin
        // LUI is executed as $zero | (imm << 16).
        reg1_read_o     = 1'b1;
        reg1_addr_o     = NOP_ADDR;
        imm_dec         = DATA_W'({inst_i[15:0], 16'h0000});
        wd_dec          = rt;
        ctl_dec.wreg    = 1'b1;
        ctl_dec.invalid = 1'b0;
        ctl_dec.alusel  = ALUSEL_LOGIC;
        ctl_dec.aluop   = ALUOP_OR;
      end
      OP_SPECIAL: begin
        if (shamt == 5'd0) begin
          case (funct)
            FUNCT_OR, FUNCT_AND, FUNCT_XOR, FUNCT_NOR: begin
              reg1_read_o     = 1'b1;
              reg2_read_o     = 1'b1;
              wd_dec          = rd;
              ctl_dec.wreg    = 1'b1;
              ctl_dec.invalid = 1'b0;
              ctl_dec.alusel  = ALUSEL_LOGIC;
              ctl_dec.aluop   = (funct == FUNCT_OR)  ? ALUOP_OR  :
                                (funct == FUNCT_AND) ? ALUOP_AND :
                                (funct == FUNCT_XOR) ? ALUOP_XOR : ALUOP_NOR;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] reg1_res;
  logic [DATA_W-1:0] reg2_res;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_op1 (
    .read_i      (reg1_read_o),
    .addr_i      (reg1_addr_o),
    .imm_i       (imm_dec),
    .rf_data_i   (reg1_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (reg1_res)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_op2 (
    .read_i      (reg2_read_o),
    .addr_i      (reg2_addr_o),
    .imm_i       (imm_dec),
    .rf_data_i   (reg2_data_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (reg2_res)
  );

  // A load in EX (source 0) cannot supply its result yet; any operand that
  // would need it must wait. Register 0 never depends on anything.
  logic              hazard;
  logic [REG_AW-1:0] ex_wd;
  logic              op1_dep;
  logic              op2_dep;

  assign ex_wd   = fwd_wd_i[REG_AW-1:0];
  assign op1_dep = reg1_read_o && (reg1_addr_o != '0) && (reg1_addr_o == ex_wd);
  assign op2_dep = reg2_read_o && (reg2_addr_o != '0) && (reg2_addr_o == ex_wd);
  assign hazard  = ex_is_load_i && fwd_wreg_i[0] && (op1_dep || op2_dep);

  id_ex_t slot_q, slot_d;
  logic   valid_q, valid_d;

  assign in_ready_o  = flush_i | (!hazard & (!valid_q | out_ready_i));
  assign stall_req_o = hazard & in_valid_i & !flush_i;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      slot_d.ctl  = ctl_dec;
      slot_d.reg1 = reg1_res;
      slot_d.reg2 = reg2_res;
      slot_d.wd   = wd_dec;
      slot_d.pc   = pc_i;
      valid_d     = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign aluop_o        = slot_q.ctl.aluop;
  assign alusel_o       = slot_q.ctl.alusel;
  assign wreg_o         = slot_q.ctl.wreg;
  assign inst_invalid_o = slot_q.ctl.invalid;
  assign reg1_o         = slot_q.reg1;
  assign reg2_o         = slot_q.reg2;
  assign wd_o           = slot_q.wd;
  assign pc_o           = slot_q.pc;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_req_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
